conv1_feeder: RTL

Frame reader for the first convolution stage. It walks a WIDTH×HEIGHT input image held in a synchronous-read frame memory in raster order. It streams one DATA_BITS pixel per handshake into the conv1 pixel input, with start-of-frame, end-of-line and end-of-frame sidebands. It sits between the frame memory and the conv1 line buffer, and is the transmitting end of the pixel stream that the buffer consumes.

---
 rtl/conv1_pkg.sv | 20 ++
 rtl/conv1_feeder_if.sv | 29 ++
 rtl/conv1_feeder_fifo.sv | 52 +++++
 rtl/conv1_feeder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - conv1 defaults, feeder state enum and pixel sideband struct
package conv1_pkg;
    localparam int CONV1_WIDTH     = 28;
    localparam int CONV1_HEIGHT    = 36;
    localparam int CONV1_DATA_BITS = 32;
    localparam int CONV1_ADDR_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } feeder_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } sideband_t;
endpackage

// File: rtl/conv1_feeder_if.sv
// rtl/conv1_feeder_if.sv - frame-memory read port and conv1 pixel stream bundle
interface conv1_feeder_if import conv1_pkg::*; #(
    parameter int DATA_BITS = CONV1_DATA_BITS,
    parameter int ADDR_BITS = CONV1_ADDR_BITS
) ();
    logic                 mem_rd_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_rdata;
    logic [DATA_BITS-1:0] pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_sof;
    logic                 pix_eol;
    logic                 pix_eof;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/conv1_feeder_fifo.sv
// rtl/conv1_feeder_fifo.sv - 2-entry FIFO carrying a pixel and its sideband bits
module conv1_feeder_fifo import conv1_pkg::*; #(
    parameter int DATA_BITS = CONV1_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] push_data_i,
    input  sideband_t            push_sb_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] head_data_o,
    output sideband_t            head_sb_o,
    output logic [1:0]           count_o,
    output logic                 empty_o
);
    logic [DATA_BITS-1:0] data_q [2];
    sideband_t            sb_q   [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic [1:0]           count_d;

    assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            sb_q[0]   <= '0;
            sb_q[1]   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                sb_q[wr_ptr_q]   <= push_sb_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Sidebands are masked while empty so a stale eof never lingers on the bus.
    assign empty_o     = (count_q == 2'd0);
    assign count_o     = count_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_sb_o   = empty_o ? '0 : sb_q[rd_ptr_q];
endmodule

// File: rtl/conv1_feeder.sv
// rtl/conv1_feeder.sv - raster frame reader feeding conv1; CONV1_FEEDER_PAD_EN adds a zero border
module conv1_feeder import conv1_pkg::*; #(
    parameter int WIDTH     = CONV1_WIDTH,
    parameter int HEIGHT    = CONV1_HEIGHT,
    parameter int DATA_BITS = CONV1_DATA_BITS,
    parameter int ADDR_BITS = CONV1_ADDR_BITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    conv1_feeder_if.master bus
);
`ifdef CONV1_FEEDER_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int NCOL = WIDTH + 2 * PAD;
    localparam int NROW = HEIGHT + 2 * PAD;
    localparam int CB   = $clog2(NCOL) + 1;
    localparam int RB   = $clog2(NROW) + 1;
    localparam logic [CB-1:0] COL_LAST = CB'(NCOL - 1);
    localparam logic [RB-1:0] ROW_LAST = RB'(NROW - 1);

    feeder_state_t        state_q;
    logic [RB-1:0]        row_q;
    logic [CB-1:0]        col_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_pend_q;
    logic                 zero_pend_q;
    sideband_t            pend_sb_q;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 border;
    logic                 last_pos;
    logic [2:0]           credit;
    sideband_t            issue_sb;
    logic [DATA_BITS-1:0] push_data;
    logic [DATA_BITS-1:0] head_data;
    sideband_t            head_sb;
    logic [1:0]           fifo_count;
    logic                 fifo_empty;

`ifdef CONV1_FEEDER_PAD_EN
    assign border = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
`else
    assign border = 1'b0;
`endif

    // At most two pixels are ever owed to the FIFO, so a backpressured read is never lost.
    assign pop      = ~fifo_empty & bus.pix_ready;
    assign push     = rd_pend_q | zero_pend_q;
    assign credit   = {1'b0, fifo_count} + {2'b00, push};
    assign issue    = (state_q == ST_RUN) && (credit < (3'd2 + {2'b00, pop}));
    assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign issue_sb = {(row_q == '0) && (col_q == '0), col_q == COL_LAST, last_pos};
    assign push_data = zero_pend_q ? '0 : bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            pend_sb_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            rd_pend_q   <= issue & ~border;
            zero_pend_q <= issue & border;
            if (issue) begin
                pend_sb_q <= issue_sb;
                if (!border) begin
                    addr_q <= addr_q + 1'b1;
                end
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && last_pos) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_sb.eof) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    conv1_feeder_fifo #(.DATA_BITS(DATA_BITS)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .push_sb_i   (pend_sb_q),
        .pop_i       (pop),
        .head_data_o (head_data),
        .head_sb_o   (head_sb),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign bus.mem_rd_en = issue & ~border;
    assign bus.mem_addr  = addr_q;
    assign bus.pix_data  = head_data;
    assign bus.pix_valid = ~fifo_empty;
    assign bus.pix_sof   = head_sb.sof;
    assign bus.pix_eol   = head_sb.eol;
    assign bus.pix_eof   = head_sb.eof;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule
